// File: rtl/sa_ctrl_pkg.sv
// Shared types and constants for the systolic-array job sequencer.
package sa_ctrl_pkg;

    // Array geometry: number of arrays and rows/columns per array.
    localparam int SA_NUM                = 4;
    localparam int SA_DIM                = 16;
    localparam int DRAIN_TIMEOUT_DEFAULT = 64;

    // Derived widths.
    localparam int WADDR_W = $clog2(SA_DIM);
    localparam int ROWS_W  = 8;

    // Sequencer states; IDLE must encode as zero so reset and idle coincide.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        SWITCH = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // True while the arrays are owned by a job and must see the latched mask.
    function automatic logic array_active(input state_t s);
        return (s == LOAD_W) || (s == SWITCH) || (s == STREAM) || (s == DRAIN);
    endfunction

    // True in the states where finished output rows are counted.
    function automatic logic counting(input state_t s);
        return (s == STREAM) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/sa_sequencer.sv
// Job sequencer for a bank of systolic arrays: loads weights, switches the
// weight bank, streams input rows, then waits for the result rows to drain.
// Every output is driven from a flop; the combinational block computes the
// values each output must take in the coming cycle.
module sa_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SA_NUM-1:0]   cfg_enable,
    input  logic [ROWS_W-1:0]   cfg_rows,
    input  logic [SA_NUM-1:0]   col_valid,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                weight_rd_en,
    output logic [WADDR_W-1:0]  weight_rd_addr,
    output logic                input_rd_en,
    output logic [ROWS_W-1:0]   input_rd_addr,
    output logic [SA_NUM-1:0]   sa_enable,
    output logic                sa_new_weight,
    output logic                sa_switch_in,
    output logic                sa_valid_in,
    output logic [ROWS_W-1:0]   out_count
);

    // Width of the drain idle counter; it must be able to hold DRAIN_TIMEOUT-1.
    localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

    // Internal state and latched job configuration.
    state_t              state,     state_next;
    logic [ROWS_W-1:0]   cnt,       cnt_next;
    logic [TO_W-1:0]     idle_cnt,  idle_cnt_next;
    logic [SA_NUM-1:0]   mask_q,    mask_next;
    logic [ROWS_W-1:0]   rows_q,    rows_next;
    logic [ROWS_W-1:0]   out_count_next;
    logic                err_next;

    // Next values of the registered outputs.
    logic                busy_next;
    logic                done_next;
    logic                weight_rd_en_next;
    logic [WADDR_W-1:0]  weight_rd_addr_next;
    logic                input_rd_en_next;
    logic [ROWS_W-1:0]   input_rd_addr_next;
    logic [SA_NUM-1:0]   sa_enable_next;
    logic                sa_new_weight_next;
    logic                sa_switch_in_next;
    logic                sa_valid_in_next;

    // A result row arrived on at least one array that belongs to this job.
    logic hit;
    assign hit = |(col_valid & mask_q);

    // Next-state, counter and output decode.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        state_next     = state;
        cnt_next       = cnt;
        idle_cnt_next  = idle_cnt;
        mask_next      = mask_q;
        rows_next      = rows_q;
        err_next       = err;
        out_count_next = out_count;

        // Output rows are counted in STREAM and DRAIN, saturating at all-ones.
        if (counting(state) && hit && (out_count != '1)) begin
            out_count_next = out_count + 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    mask_next      = cfg_enable;
                    rows_next      = cfg_rows;
                    err_next       = 1'b0;
                    out_count_next = '0;
                    cnt_next       = '0;
                    idle_cnt_next  = '0;
                    if (cfg_enable == '0) begin
                        // Nothing to run on: flag it and finish immediately.
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = LOAD_W;
                    end
                end
            end

            LOAD_W: begin
                if (cnt == ROWS_W'(SA_DIM - 1)) begin
                    cnt_next   = '0;
                    state_next = SWITCH;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            SWITCH: begin
                cnt_next   = '0;
                state_next = (rows_q == '0) ? DONE : STREAM;
            end

            STREAM: begin
                if (cnt == rows_q - 1'b1) begin
                    idle_cnt_next = '0;
                    state_next    = DRAIN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            DRAIN: begin
                if (out_count == rows_q) begin
                    state_next = DONE;
                end else if (hit) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt == TO_W'(DRAIN_TIMEOUT - 1)) begin
                    // The arrays stopped producing rows: give up on the job.
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    idle_cnt_next = idle_cnt + 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs for the coming cycle follow from the coming state.
        busy_next           = (state_next != IDLE);
        done_next           = (state_next == DONE);
        weight_rd_en_next   = (state_next == LOAD_W);
        sa_new_weight_next  = (state_next == LOAD_W);
        weight_rd_addr_next = (state_next == LOAD_W) ? cnt_next[WADDR_W-1:0] : '0;
        sa_switch_in_next   = (state_next == SWITCH);
        input_rd_en_next    = (state_next == STREAM);
        sa_valid_in_next    = (state_next == STREAM);
        input_rd_addr_next  = (state_next == STREAM) ? cnt_next : '0;
        sa_enable_next      = array_active(state_next) ? mask_next : '0;
    end

    // State, configuration, counters and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            idle_cnt       <= '0;
            mask_q         <= '0;
            rows_q         <= '0;
            out_count      <= '0;
            err            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            weight_rd_en   <= 1'b0;
            weight_rd_addr <= '0;
            input_rd_en    <= 1'b0;
            input_rd_addr  <= '0;
            sa_enable      <= '0;
            sa_new_weight  <= 1'b0;
            sa_switch_in   <= 1'b0;
            sa_valid_in    <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            idle_cnt       <= idle_cnt_next;
            mask_q         <= mask_next;
            rows_q         <= rows_next;
            out_count      <= out_count_next;
            err            <= err_next;
            busy           <= busy_next;
            done           <= done_next;
            weight_rd_en   <= weight_rd_en_next;
            weight_rd_addr <= weight_rd_addr_next;
            input_rd_en    <= input_rd_en_next;
            input_rd_addr  <= input_rd_addr_next;
            sa_enable      <= sa_enable_next;
            sa_new_weight  <= sa_new_weight_next;
            sa_switch_in   <= sa_switch_in_next;
            sa_valid_in    <= sa_valid_in_next;
        end
    end

endmodule

// File: doc/sa_sequencer.md
SA_SEQUENCER -- requirements
Module: sa_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-004 SHALL have port cfg_enable  input  4  per-array enable mask; latched on accepted start.
REQ-005 SHALL have port cfg_rows  input  8  input rows per job; latched on accepted start.
REQ-006 SHALL have port col_valid  input  4  last-column valid of each array (array i column 15).
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port err  output  1  sticky error flag; cleared on the next accepted start.
REQ-010 SHALL have port weight_rd_en / weight_rd_addr  output  1 / 4  weight buffer read strobe and row index.
REQ-011 SHALL have port input_rd_en / input_rd_addr  output  1 / 8  input buffer read strobe and row index.
REQ-012 SHALL have port sa_enable  output  4  registered array enables driven to the array.
REQ-013 SHALL have ports sa_new_weight, sa_switch_in, sa_valid_in  output  1 each  array control strobes.
REQ-014 SHALL have port out_count  output  8  number of output rows seen in the current job.
REQ-015 Parameter DRAIN_TIMEOUT, default 64, is the maximum idle cycles in DRAIN.

Function
REQ-016 States SHALL be IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE; all outputs SHALL be registered.
REQ-017 In IDLE, start=1 SHALL latch cfg_enable and cfg_rows, clear err and out_count, and enter LOAD_W the next cycle.
REQ-018 start while busy SHALL be ignored with no effect.
REQ-019 start with cfg_enable=0 SHALL set err and go directly to DONE.
REQ-020 LOAD_W SHALL last exactly 16 cycles, with weight_rd_en=sa_new_weight=1 and weight_rd_addr stepping 0..15; the weight buffer has combinational read.
REQ-021 SWITCH SHALL last one cycle with sa_switch_in=1 and all other strobes 0.
REQ-022 STREAM SHALL last cfg_rows cycles, with input_rd_en=sa_valid_in=1 and input_rd_addr stepping 0..cfg_rows-1.
REQ-023 cfg_rows=0 SHALL skip STREAM and DRAIN, going SWITCH->DONE.
REQ-024 sa_enable SHALL equal the latched mask from LOAD_W through DRAIN, and 0 in IDLE and DONE.
REQ-025 In STREAM and DRAIN, out_count SHALL increment on each cycle in which any enabled bit of col_valid is 1, saturating at 255.
REQ-026 DRAIN SHALL exit to DONE when out_count==cfg_rows.
REQ-027 DRAIN SHALL also exit to DONE with err=1 after DRAIN_TIMEOUT consecutive cycles with no enabled col_valid.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; out_count SHALL hold until the next accepted start.
REQ-029 col_valid bits of disabled arrays SHALL be ignored.

Reset
REQ-030 rst SHALL force state IDLE and all outputs, counters and latched configuration to 0 on the next edge.
REQ-031 rst asserted mid-job SHALL abort the job with no done pulse; start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-032 Package sa_ctrl_pkg SHALL hold the state enum and the constants SA_NUM=4, SA_DIM=16 and DRAIN_TIMEOUT default.
REQ-033 The block SHALL be a single module with no sub-modules; counters and the FSM are inline.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- start, mask=4'b1111, rows=20, col_valid returns 20 rows -> 16 LOAD_W cycles, 1 SWITCH cycle, 20 STREAM cycles (addr 0..19), done pulse, out_count=20, err=0.
- rows=0, mask=4'b0011 -> SWITCH then DONE; input_rd_en never high; done=1.
- mask=0 -> err=1, done pulse one cycle after start; sa_enable stays 0.
- rows=5, col_valid held 0 -> DRAIN times out after 64 cycles; err=1, done=1, out_count=0.
- start pulsed during STREAM -> ignored; cfg_rows change mid-job has no effect.
- rst asserted in the 8th LOAD_W cycle -> next cycle IDLE, all outputs 0, no done pulse.
